// File: rtl/viterbi_ctrl_pkg.sv
// Shared types and width helpers for the Viterbi loopback frame controller.
package viterbi_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StSend,
        StTail,
        StDrain,
        StDone
    } ctrl_state_t;

    // Index width for a counter running 0..n-1; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must be able to hold the value n itself.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/viterbi_tag_delay.sv
// DEPTH-stage tag shift register marking which decoder outputs carry frame data.
module viterbi_tag_delay #(
    parameter int unsigned DEPTH = 64
) (
    input  logic clk,
    input  logic clr_i,
    input  logic tag_i,
    output logic tag_o,
    output logic any_o
);

    logic [DEPTH-1:0] pipe_q;

    if (DEPTH == 1) begin : g_single
        always_ff @(posedge clk) begin
            if (clr_i) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= tag_i;
            end
        end
    end else begin : g_shift
        always_ff @(posedge clk) begin
            if (clr_i) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= {pipe_q[DEPTH-2:0], tag_i};
            end
        end
    end

    assign tag_o = pipe_q[DEPTH-1];
    assign any_o = |pipe_q;

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Loopback frame sequencer: buffers a frame, bursts it into the encoder with a zero tail,
// then aligns, forwards and scores the decoder output against the buffered source.
module viterbi_frame_ctrl
    import viterbi_ctrl_pkg::*;
#(
    parameter int unsigned FRAME_LEN   = 256,
    parameter int unsigned TAIL_LEN    = 8,
    parameter int unsigned DEC_LATENCY = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_i,
    input  logic                           src_valid_i,
    input  logic                           src_data_i,
    output logic                           src_ready_o,
    output logic                           enc_bit_o,
    output logic                           enc_en_o,
    input  logic                           dec_bit_i,
    output logic                           out_valid_o,
    output logic                           out_data_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic [$clog2(FRAME_LEN+1)-1:0] err_cnt_o
);

    localparam int unsigned IdxW  = idx_width(FRAME_LEN);
    localparam int unsigned TailW = idx_width(TAIL_LEN);
    localparam int unsigned ErrW  = cnt_width(FRAME_LEN);

    ctrl_state_t state_q, state_d;

    logic [IdxW-1:0]  wr_idx_q, wr_idx_d;
    logic [IdxW-1:0]  rd_idx_q, rd_idx_d;
    logic [IdxW-1:0]  cmp_idx_q, cmp_idx_d;
    logic [TailW-1:0] tail_cnt_q, tail_cnt_d;
    logic [ErrW-1:0]  err_cnt_q, err_cnt_d;

    logic buf_q [FRAME_LEN];

    logic enc_en_q, enc_bit_q, tag_q;
    logic out_valid_q, out_data_q;
    logic tag_out, tag_any;

    always_comb begin
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        tail_cnt_d = tail_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d    = StFill;
                    wr_idx_d   = '0;
                    rd_idx_d   = '0;
                    tail_cnt_d = '0;
                end
            end
            StFill: begin
                if (src_valid_i) begin
                    wr_idx_d = wr_idx_q + IdxW'(1);
                    if (wr_idx_q == IdxW'(FRAME_LEN - 1)) begin
                        state_d = StSend;
                    end
                end
            end
            StSend: begin
                rd_idx_d = rd_idx_q + IdxW'(1);
                if (rd_idx_q == IdxW'(FRAME_LEN - 1)) begin
                    state_d = StTail;
                end
            end
            StTail: begin
                if (tail_cnt_q == TailW'(TAIL_LEN - 1)) begin
                    state_d    = StDrain;
                    tail_cnt_d = '0;
                end else begin
                    tail_cnt_d = tail_cnt_q + TailW'(1);
                end
            end
            // An empty tag pipe means the final compare was registered on the previous edge.
            StDrain: begin
                if (!tag_any) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmp_idx_d = cmp_idx_q;
        err_cnt_d = err_cnt_q;
        if (state_q == StIdle && start_i) begin
            cmp_idx_d = '0;
            err_cnt_d = '0;
        end else if (tag_out) begin
            cmp_idx_d = cmp_idx_q + IdxW'(1);
            if (dec_bit_i != buf_q[cmp_idx_q] && err_cnt_q != ErrW'(FRAME_LEN)) begin
                err_cnt_d = err_cnt_q + ErrW'(1);
            end
        end
    end

    // Buffer is only written in FILL so compare data stays stable until the next frame.
    always_ff @(posedge clk) begin
        if (state_q == StFill && src_valid_i) begin
            buf_q[wr_idx_q] <= src_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            cmp_idx_q   <= '0;
            tail_cnt_q  <= '0;
            err_cnt_q   <= '0;
            enc_en_q    <= 1'b0;
            enc_bit_q   <= 1'b0;
            tag_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            cmp_idx_q   <= cmp_idx_d;
            tail_cnt_q  <= tail_cnt_d;
            err_cnt_q   <= err_cnt_d;
            enc_en_q    <= (state_q == StSend) || (state_q == StTail);
            enc_bit_q   <= (state_q == StSend) && buf_q[rd_idx_q];
            tag_q       <= (state_q == StSend);
            out_valid_q <= tag_out;
            out_data_q  <= tag_out && dec_bit_i;
        end
    end

    viterbi_tag_delay #(
        .DEPTH(DEC_LATENCY)
    ) u_tag_delay (
        .clk  (clk),
        .clr_i(rst),
        .tag_i(tag_q),
        .tag_o(tag_out),
        .any_o(tag_any)
    );

    assign src_ready_o = (state_q == StFill);
    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);
    assign enc_en_o    = enc_en_q;
    assign enc_bit_o   = enc_bit_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: doc/viterbi_frame_ctrl.md
Name: viterbi_frame_ctrl

Overview:
- Frame sequencer for the viterbi_tx_rx encode/decode datapath.
- Buffers one frame of source bits (stalls allowed), then streams them to the encoder as a gap-free burst, followed by TAIL_LEN zero flush bits.
- Aligns decoder_o to the fed data using a tag delay line, forwards the decoded bits, and scores them against the buffered originals.
- Replaces hand-timed encoder stimulus and fixed-delay capture with a self-contained, latency-aware loopback controller.

Parameters:
- FRAME_LEN, 256, data bits per frame (power of two, >=2)
- TAIL_LEN, 8, zero flush bits after data (>=1; covers encoder memory)
- DEC_LATENCY, 64, cycles from encoder bit presented (with enable) to the matching bit on decoder_o (>=1)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous reset, active-high
- start_i  in  1  begin a frame; sampled only in IDLE
- src_valid_i  in  1  source bit valid
- src_data_i  in  1  source bit
- src_ready_o  out  1  high in FILL; transfer = src_valid_i & src_ready_o
- enc_bit_o  out  1  to viterbi_tx_rx encoder_i
- enc_en_o  out  1  to viterbi_tx_rx enable_encoder_i
- dec_bit_i  in  1  from viterbi_tx_rx decoder_o
- out_valid_o  out  1  decoded data bit valid; no backpressure
- out_data_o  out  1  decoded data bit
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse at frame end
- err_cnt_o  out  $clog2(FRAME_LEN+1)  mismatches in last frame

Behaviour:
- Reset: state=IDLE; all outputs 0; indices, tag pipe and err_cnt cleared. Reset mid-frame aborts immediately; no done_o.
- States: IDLE, FILL, SEND, TAIL, DRAIN, DONE.
- IDLE:
  - start_i=1 -> FILL next cycle; err_cnt cleared at this transition.
  - start_i outside IDLE is ignored.
- FILL:
  - src_ready_o=1; each transfer writes buf[wr_idx], wr_idx++.
  - Transfer with wr_idx=FRAME_LEN-1 -> SEND.
  - Gaps in src_valid_i only extend FILL.
- SEND: enc_en_o=1, enc_bit_o=buf[rd_idx], tag_in=1 for exactly FRAME_LEN consecutive cycles (rd_idx 0..FRAME_LEN-1) -> TAIL.
- TAIL: enc_en_o=1, enc_bit_o=0, tag_in=0 for TAIL_LEN cycles -> DRAIN.
- DRAIN: enc_en_o=0, tag_in=0; exit to DONE when the tag pipe is empty and the last compare has been registered.
- DONE: done_o=1 for one cycle; err_cnt_o holds final value -> IDLE.
- enc_en_o / enc_bit_o are registered outputs; the tag enters the delay line in the same cycle enc_en_o is high.
- Tag delay line: DEC_LATENCY stages. When tag_out=1 in a cycle, dec_bit_i in that cycle is data bit cmp_idx. In the next cycle:
  - out_valid_o=1, out_data_o=that bit;
  - err_cnt increments if the bit != buf[cmp_idx];
  - cmp_idx++.
- Exactly FRAME_LEN out_valid_o pulses per frame, contiguous, in source order. Tail bits are never forwarded.
- done_o asserts the cycle after the last out_valid_o.
- err_cnt saturates at FRAME_LEN (cannot exceed it by construction). It holds from DONE until the next accepted start_i.
- The buffer is not written outside FILL, so compare data stays stable through DRAIN.
- Index widths: $clog2(FRAME_LEN). Index wrap at FRAME_LEN-1 -> 0 coincides with the state change.

Decomposition:
- viterbi_ctrl_pkg:
  - state enum ctrl_state_t {IDLE, FILL, SEND, TAIL, DRAIN, DONE}
  - localparam helpers for index and count widths.
- Sub-module viterbi_tag_delay: parameterised DEPTH shift register with synchronous active-high clear, plus an any-tag-in-flight flag used for DRAIN exit.
- Frame buffer: an inferred 1-bit x FRAME_LEN array inside viterbi_frame_ctrl.

Test Plan:
- Reset/idle: hold rst 3 cycles -> all outputs 0, busy_o=0. With start_i=0, no state change for 100 cycles.
- Clean loopback (ideal decoder model, DEC_LATENCY=64): feed the repeating pattern 1,0,0,1,1,0,0,0, src_valid_i always 1.
  - Required: FILL lasts 256 cycles, then enc_en_o high for 264 contiguous cycles (last 8 bits 0).
  - Required: 256 out_valid_o pulses matching the input exactly; done_o pulses; err_cnt_o=0.
- Source stalls: src_valid_i toggled 1,0,0 repeatedly over 256 bits -> FILL lasts 766 cycles; SEND is still 256 gap-free cycles; output identical to input.
- Error scoring: decoder model inverts data bits 3, 100 and 255 -> out_data_o shows the inversions and err_cnt_o=3.
- Boundary config: FRAME_LEN=2, TAIL_LEN=1, DEC_LATENCY=1 -> 2 outputs; done_o one cycle after the second output.
- Mid-frame reset and start while busy:
  - start_i pulsed during SEND is ignored (frame unaffected).
  - rst asserted during DRAIN -> next cycle busy_o=0, no done_o, no further out_valid_o.
  - A following frame completes with err_cnt_o=0.
